// File: rtl/otter_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otter_pipe_ctrl
// Description : Central pipeline sequencer for the 5-stage OTTER core
//               (IF, DE, EX, MEM, WB). Produces per-stage register enables
//               and bubble/flush controls from load-use hazards, EX-resolved
//               control redirects, multi-cycle data-memory accesses and
//               external interrupts. Interrupts are drained through a small
//               RUN/DRAIN/TAKE state machine before o_int_taken is pulsed.
//
// Parameters  : DRAIN_CYC - non-frozen cycles spent draining before the
//                           interrupt is taken (1..15)
//               CNT_W     - width of the saturating stall-cycle counter
//
// Ports       : i_clk, i_rst_n          clock, async active-low reset
//               i_dec_rs1/rs2           source registers of DE instruction
//               i_dec_uses_rs1/rs2      DE instruction reads rs1 / rs2
//               i_exe_rd, i_exe_is_load destination / load flag of EX instr
//               i_exe_redirect          EX resolved a taken control transfer
//               i_mem_access, i_mem_ack MEM load/store and its completion
//               i_intr, i_int_en        level interrupt and mstatus.MIE
//               o_pc_en .. o_mem_wb_en  stage register enables
//               o_flush_de, o_flush_ex  load NOP into IF/DE, DE/EX
//               o_int_taken             one-cycle interrupt-take pulse
//               o_int_busy              sequencer in DRAIN or TAKE
//               o_stall_cnt             saturating stall-cycle count
//
// Revision    : 1.0 - initial release
// ============================================================================
module otter_pipe_ctrl #(
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic             i_dec_uses_rs1,
    input  logic             i_dec_uses_rs2,
    input  logic [4:0]       i_exe_rd,
    input  logic             i_exe_is_load,
    input  logic             i_exe_redirect,
    input  logic             i_mem_access,
    input  logic             i_mem_ack,
    input  logic             i_intr,
    input  logic             i_int_en,
    output logic             o_pc_en,
    output logic             o_if_de_en,
    output logic             o_de_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_flush_de,
    output logic             o_flush_ex,
    output logic             o_int_taken,
    output logic             o_int_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int         c_DCNT_W   = 4;
    localparam logic [c_DCNT_W-1:0] c_DCNT_LOAD = c_DCNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TAKE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_DCNT_W-1:0]   r_dcnt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_freeze;
    logic w_luh;
    logic w_stall_evt;

    // A memory access that has not been acknowledged freezes every stage.
    assign w_freeze = i_mem_access & ~i_mem_ack;

    // x0 is never a real dependency, so a load to x0 never stalls.
    assign w_luh = i_exe_is_load & (i_exe_rd != 5'd0) &
                   ((i_dec_uses_rs1 & (i_dec_rs1 == i_exe_rd)) |
                    (i_dec_uses_rs2 & (i_dec_rs2 == i_exe_rd)));

    // Only true bubbles count: a load-use stall that a redirect overrides
    // costs no extra cycle, and DRAIN-time hazards are not stalls of the
    // fetch stream.
    assign w_stall_evt = w_freeze |
                         ((r_state == ST_RUN) & w_luh & ~i_exe_redirect);

    // ------------------------------------------------------------------
    // Combinational stage controls
    // ------------------------------------------------------------------
    always_comb begin
        o_pc_en     = 1'b1;
        o_if_de_en  = 1'b1;
        o_de_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
        o_flush_de  = 1'b0;
        o_flush_ex  = 1'b0;
        o_int_taken = 1'b0;
        o_int_busy  = (r_state == ST_DRAIN) | (r_state == ST_TAKE);

        if (!i_rst_n) begin
            // Hold the whole pipe with NOPs in the front latches.
            o_pc_en     = 1'b0;
            o_if_de_en  = 1'b0;
            o_de_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
            o_flush_de  = 1'b1;
            o_flush_ex  = 1'b1;
            o_int_busy  = 1'b0;
        end else if (w_freeze) begin
            o_pc_en     = 1'b0;
            o_if_de_en  = 1'b0;
            o_de_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_exe_redirect) begin
                        // Kill the two wrong-path instructions in IF and DE.
                        o_flush_de = 1'b1;
                        o_flush_ex = 1'b1;
                    end else if (w_luh) begin
                        // Hold IF/DE and PC, inject a bubble into EX; the
                        // load moves on so the bubble lasts one cycle.
                        o_pc_en    = 1'b0;
                        o_if_de_en = 1'b0;
                        o_flush_ex = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // No new work enters DE; PC only moves to capture a
                    // redirect target so it becomes the saved return PC.
                    o_pc_en    = i_exe_redirect;
                    o_flush_de = 1'b1;
                    o_flush_ex = i_exe_redirect | w_luh;
                end
                ST_TAKE: begin
                    o_int_taken = 1'b1;
                    o_flush_de  = 1'b1;
                    o_flush_ex  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state, drain counter and stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_dcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end

            // A frozen cycle holds the sequencer exactly where it is.
            if (!w_freeze) begin
                case (r_state)
                    ST_RUN: begin
                        if (i_intr && i_int_en) begin
                            r_state <= ST_DRAIN;
                            r_dcnt  <= c_DCNT_LOAD;
                        end
                    end
                    ST_DRAIN: begin
                        // Once entered, the drain runs to completion even if
                        // the interrupt request goes away.
                        if (r_dcnt == '0) begin
                            r_state <= ST_TAKE;
                        end else begin
                            r_dcnt <= r_dcnt - 4'd1;
                        end
                    end
                    ST_TAKE: begin
                        r_state <= ST_RUN;
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage OTTER core (IF, DE, EX, MEM, WB).
- Generates the per-stage register enables and bubble/flush controls from four sources:
  - load-use hazards between DE and EX
  - control redirects resolved in EX
  - multi-cycle data-memory accesses in MEM
  - external interrupts
- Interrupts are drained through a small FSM before INT_TAKEN is pulsed. The decoders consume INT_TAKEN to select PC_SOURCE=4.

Parameters:
- DRAIN_CYC, 3, non-frozen cycles spent draining older instructions before an interrupt is taken (1..15).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  core clock
- RST_N  in  1  reset, asynchronous, active-low
- DEC_RS1  in  5  rs1 of instruction in DE
- DEC_RS2  in  5  rs2 of instruction in DE
- DEC_USES_RS1  in  1  DE instruction reads rs1
- DEC_USES_RS2  in  1  DE instruction reads rs2
- EXE_RD  in  5  rd of instruction in EX
- EXE_IS_LOAD  in  1  EX instruction is a LOAD
- EXE_REDIRECT  in  1  EX resolved a taken branch, JAL or JALR (PC_SOURCE≠0)
- MEM_ACCESS  in  1  MEM instruction is a load/store
- MEM_ACK  in  1  data memory completes the access this cycle
- INTR  in  1  external interrupt, level
- INT_EN  in  1  mstatus.MIE
- PC_EN  out  1  PC register load enable
- IF_DE_EN  out  1  IF/DE register enable
- DE_EX_EN  out  1  DE/EX register enable
- EX_MEM_EN  out  1  EX/MEM register enable
- MEM_WB_EN  out  1  MEM/WB register enable
- FLUSH_DE  out  1  load NOP into IF/DE on next edge
- FLUSH_EX  out  1  load NOP into DE/EX on next edge
- INT_TAKEN  out  1  one-cycle interrupt-take pulse
- INT_BUSY  out  1  FSM in DRAIN or TAKE
- STALL_CNT  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: RUN, DRAIN, TAKE.
- Registered state: FSM state, drain counter dcnt, STALL_CNT.
- All other outputs are combinational from registered state plus inputs.
- Reset (RST_N=0, asynchronous):
  - state=RUN, dcnt=0, STALL_CNT=0.
  - While RST_N=0 the combinational outputs are forced: all *_EN=0, FLUSH_DE=1, FLUSH_EX=1, INT_TAKEN=0, INT_BUSY=0.
- Signal definitions:
  - freeze = MEM_ACCESS & ~MEM_ACK
  - luh = EXE_IS_LOAD & (EXE_RD≠0) & ((DEC_USES_RS1 & DEC_RS1==EXE_RD) | (DEC_USES_RS2 & DEC_RS2==EXE_RD))
- Priority each cycle: freeze > EXE_REDIRECT > luh > interrupt entry.
- freeze (any state):
  - All *_EN=0, FLUSH_DE=0, FLUSH_EX=0.
  - State and dcnt hold. INT_TAKEN=0 even in TAKE; TAKE persists until a non-frozen cycle.
- RUN, redirect:
  - All *_EN=1, FLUSH_DE=1, FLUSH_EX=1 (the two wrong-path instructions are killed).
- RUN, luh without redirect:
  - PC_EN=0, IF_DE_EN=0, DE_EX_EN=1, FLUSH_EX=1, EX_MEM_EN=1, MEM_WB_EN=1.
  - Exactly a one-cycle bubble, because the load leaves EX.
- RUN, otherwise:
  - All *_EN=1, flushes 0.
- RUN → DRAIN:
  - Condition: INTR & INT_EN & ~freeze. Redirect and luh effects still apply in that cycle.
  - dcnt loaded with DRAIN_CYC-1.
- DRAIN:
  - IF_DE_EN=1, FLUSH_DE=1 (no new instructions enter DE).
  - DE_EX_EN, EX_MEM_EN, MEM_WB_EN = 1.
  - FLUSH_EX = EXE_REDIRECT | luh.
  - PC_EN = EXE_REDIRECT, so a redirect target is captured in PC for mepc.
  - dcnt decrements on non-frozen cycles. Go to TAKE when dcnt==0 and not frozen.
  - INTR/INT_EN deassertion during DRAIN does not abort the sequence.
- TAKE (non-frozen):
  - INT_TAKEN=1, PC_EN=1, IF_DE_EN=1, FLUSH_DE=1, FLUSH_EX=1.
  - Next state RUN.
  - INT_BUSY=1 in DRAIN and TAKE.
- STALL_CNT:
  - Increments on every cycle with RST_N=1 and (freeze, or RUN & luh & ~EXE_REDIRECT).
  - Saturates at 2^CNT_W-1; no wrap.
- Async reset mid-DRAIN/TAKE: immediate return to RUN, no INT_TAKEN pulse.

Test Plan:
- LW x5 in EX (EXE_RD=5), DE ADD with DEC_RS2=5, DEC_USES_RS2=1 → one cycle: PC_EN=0, IF_DE_EN=0, FLUSH_EX=1; STALL_CNT 0→1. Same with EXE_RD=0 → no stall.
- EXE_REDIRECT=1 with luh also true → FLUSH_DE=FLUSH_EX=1, PC_EN=1, STALL_CNT unchanged.
- MEM_ACCESS=1, MEM_ACK=0 for 4 cycles then ACK → all enables 0 for 4 cycles, STALL_CNT=4, normal enables on the ACK cycle.
- INTR=INT_EN=1 one cycle in RUN, DRAIN_CYC=3 → INT_BUSY high 4 cycles, INT_TAKEN pulses exactly once in cycle 4, FLUSH_DE=1 throughout.
- INTR during DRAIN with freeze in the 2nd drain cycle → INT_TAKEN delayed by exactly 1 cycle. EXE_REDIRECT in drain → PC_EN=1 that cycle only.
- Force STALL_CNT near max (CNT_W=4, 20 freeze cycles) → STALL_CNT=15. RST_N pulsed low mid-DRAIN → state RUN, STALL_CNT=0, no INT_TAKEN.
